// File: rtl/rst_sequencer_if.sv
// ---------------------------------------------------------------------------
// rst_sequencer_if
// Groups the control and status signals of the staged reset sequencer.
//   master : control side (software request, per-stage ready), reads status
//   slave  : the sequencer itself
// ---------------------------------------------------------------------------
interface rst_sequencer_if #(
    parameter int NUM_STAGES = 4
);
    localparam int CW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

    logic                  sw_rst_req;
    logic [NUM_STAGES-1:0] stage_ready;
    logic [NUM_STAGES-1:0] stage_rst_n;
    logic [CW-1:0]         cur_stage;
    logic                  busy;
    logic                  seq_done;
    logic [NUM_STAGES-1:0] timeout_err;

    modport master (
        output sw_rst_req,
        output stage_ready,
        input  stage_rst_n,
        input  cur_stage,
        input  busy,
        input  seq_done,
        input  timeout_err
    );

    modport slave (
        input  sw_rst_req,
        input  stage_ready,
        output stage_rst_n,
        output cur_stage,
        output busy,
        output seq_done,
        output timeout_err
    );
endinterface

// File: rtl/rst_sequencer.sv
// ---------------------------------------------------------------------------
// rst_sequencer
// Staged reset controller: all stage resets assert together, then release one
// at a time in index order. Each release waits for the previous stage's ready
// handshake plus a fixed gap. A one-cycle software request restarts the whole
// sequence from the hold phase.
//
// Optional feature macro: RST_SEQ_TIMEOUT_EN
//   defined   - a stage that never reports ready is given up on after
//               TIMEOUT_CYCLES, flagged in timeout_err, and the sequence moves on
//   undefined - the sequencer waits for ready indefinitely, timeout_err is 0
// ---------------------------------------------------------------------------
module rst_sequencer #(
    parameter int NUM_STAGES     = 4,
    parameter int HOLD_CYCLES    = 16,
    parameter int GAP_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic           clk,
    input  logic           rst_n,
    rst_sequencer_if.slave bus
);
    localparam int CW = (NUM_STAGES > 1)  ? $clog2(NUM_STAGES)  : 1;
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int GW = (GAP_CYCLES > 1)  ? $clog2(GAP_CYCLES)  : 1;

    localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST   = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : GW'(0);
    localparam logic [CW-1:0] LAST_STAGE = CW'(NUM_STAGES - 1);

    // Reject configurations the sequencing scheme cannot represent.
    if ((NUM_STAGES < 2) || (HOLD_CYCLES < 1) || (GAP_CYCLES < 0) || (TIMEOUT_CYCLES < 1)) begin : g_param_err
        $error("rst_sequencer: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        S_HOLD    = 3'd0,
        S_RELEASE = 3'd1,
        S_WAIT    = 3'd2,
        S_GAP     = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t                state_r,       state_nx;
    logic [HW-1:0]         hold_cnt_r,    hold_cnt_nx;
    logic [GW-1:0]         gap_cnt_r,     gap_cnt_nx;
    logic [CW-1:0]         cur_stage_r,   cur_stage_nx;
    logic [NUM_STAGES-1:0] stage_rst_n_r, stage_rst_n_nx;
    logic                  busy_r,        busy_nx;
    logic                  seq_done_r,    seq_done_nx;
    logic                  stage_done_s;

`ifdef RST_SEQ_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0]         to_cnt_r,      to_cnt_nx;
    logic [NUM_STAGES-1:0] timeout_err_r, timeout_err_nx;
`endif

    // Next-state and next-output logic; a software request overrides everything.
    always_comb begin
        state_nx       = state_r;
        hold_cnt_nx    = hold_cnt_r;
        gap_cnt_nx     = gap_cnt_r;
        cur_stage_nx   = cur_stage_r;
        stage_rst_n_nx = stage_rst_n_r;
        busy_nx        = busy_r;
        seq_done_nx    = seq_done_r;
        stage_done_s   = 1'b0;
`ifdef RST_SEQ_TIMEOUT_EN
        to_cnt_nx      = to_cnt_r;
        timeout_err_nx = timeout_err_r;
`endif

        if (bus.sw_rst_req) begin
            state_nx       = S_HOLD;
            hold_cnt_nx    = '0;
            gap_cnt_nx     = '0;
            cur_stage_nx   = '0;
            stage_rst_n_nx = '0;
            busy_nx        = 1'b1;
            seq_done_nx    = 1'b0;
`ifdef RST_SEQ_TIMEOUT_EN
            to_cnt_nx      = '0;
            timeout_err_nx = '0;
`endif
        end else begin
            case (state_r)
                S_HOLD: begin
                    if (hold_cnt_r == HOLD_LAST) begin
                        hold_cnt_nx = '0;
                        state_nx    = S_RELEASE;
                    end else begin
                        hold_cnt_nx = hold_cnt_r + HW'(1);
                    end
                end

                S_RELEASE: begin
                    stage_rst_n_nx[cur_stage_r] = 1'b1;
                    state_nx                    = S_WAIT;
                end

                S_WAIT: begin
                    stage_done_s = bus.stage_ready[cur_stage_r];
`ifdef RST_SEQ_TIMEOUT_EN
                    if (stage_done_s) begin
                        to_cnt_nx = '0;
                    end else if (to_cnt_r == TO_LAST) begin
                        to_cnt_nx                   = '0;
                        timeout_err_nx[cur_stage_r] = 1'b1;
                        stage_done_s                = 1'b1;
                    end else begin
                        to_cnt_nx = to_cnt_r + TW'(1);
                    end
`endif
                    if (stage_done_s) begin
                        if (cur_stage_r == LAST_STAGE) begin
                            state_nx    = S_DONE;
                            busy_nx     = 1'b0;
                            seq_done_nx = 1'b1;
                        end else if (GAP_CYCLES > 0) begin
                            state_nx = S_GAP;
                        end else begin
                            cur_stage_nx = cur_stage_r + CW'(1);
                            state_nx     = S_RELEASE;
                        end
                    end else begin
                        state_nx = S_WAIT;
                    end
                end

                S_GAP: begin
                    if (gap_cnt_r == GAP_LAST) begin
                        gap_cnt_nx   = '0;
                        cur_stage_nx = cur_stage_r + CW'(1);
                        state_nx     = S_RELEASE;
                    end else begin
                        gap_cnt_nx = gap_cnt_r + GW'(1);
                    end
                end

                S_DONE: begin
                    state_nx = S_DONE;
                end

                default: begin
                    // Unreachable encoding: fall back to a full re-sequence.
                    state_nx       = S_HOLD;
                    hold_cnt_nx    = '0;
                    gap_cnt_nx     = '0;
                    cur_stage_nx   = '0;
                    stage_rst_n_nx = '0;
                    busy_nx        = 1'b1;
                    seq_done_nx    = 1'b0;
                end
            endcase
        end
    end

    // State and output registers; rst_n forces every stage back into reset at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= S_HOLD;
            hold_cnt_r    <= '0;
            gap_cnt_r     <= '0;
            cur_stage_r   <= '0;
            stage_rst_n_r <= '0;
            busy_r        <= 1'b1;
            seq_done_r    <= 1'b0;
        end else begin
            state_r       <= state_nx;
            hold_cnt_r    <= hold_cnt_nx;
            gap_cnt_r     <= gap_cnt_nx;
            cur_stage_r   <= cur_stage_nx;
            stage_rst_n_r <= stage_rst_n_nx;
            busy_r        <= busy_nx;
            seq_done_r    <= seq_done_nx;
        end
    end

`ifdef RST_SEQ_TIMEOUT_EN
    // Ready-wait timeout counter and sticky per-stage timeout flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_r      <= '0;
            timeout_err_r <= '0;
        end else begin
            to_cnt_r      <= to_cnt_nx;
            timeout_err_r <= timeout_err_nx;
        end
    end

    assign bus.timeout_err = timeout_err_r;
`else
    assign bus.timeout_err = '0;
`endif

    assign bus.stage_rst_n = stage_rst_n_r;
    assign bus.cur_stage   = cur_stage_r;
    assign bus.busy        = busy_r;
    assign bus.seq_done    = seq_done_r;

endmodule

// File: tb/tb_rst_sequencer.sv
// ---------------------------------------------------------------------------
// tb_rst_sequencer
// Two sequencers share clock and reset: "a" (3 stages, hold 16, gap 4,
// timeout 8) and "b" (3 stages, hold 16, gap 0). Expected release edges are
// queued when a sequence is started and popped when a stage reset rises.
// ---------------------------------------------------------------------------
module tb_rst_sequencer;
    localparam int NS = 3;

    typedef struct packed {
        int stage;
        int edge_no;
    } rel_t;

    logic clk;
    logic rst_n;
    int   edge_n;
    int   n_pass;
    int   n_total;
    int   base;
    int   base2;
    rel_t qa[$];
    rel_t qb[$];
    logic [NS-1:0] prev_a;
    logic [NS-1:0] prev_b;

    rst_sequencer_if #(.NUM_STAGES(NS)) ifa ();
    rst_sequencer_if #(.NUM_STAGES(NS)) ifb ();

    rst_sequencer #(
        .NUM_STAGES(NS), .HOLD_CYCLES(16), .GAP_CYCLES(4), .TIMEOUT_CYCLES(8)
    ) u_dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ifa)
    );

    rst_sequencer #(
        .NUM_STAGES(NS), .HOLD_CYCLES(16), .GAP_CYCLES(0), .TIMEOUT_CYCLES(8)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ifb)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic chk_a(input string tag, input logic [2:0] sr, input int cur,
                         input logic bsy, input logic dn, input logic [2:0] terr);
        check({tag, ".a.stage_rst_n"}, 32'(ifa.stage_rst_n), 32'(sr));
        check({tag, ".a.cur_stage"},   32'(ifa.cur_stage),   cur);
        check({tag, ".a.busy"},        32'(ifa.busy),        32'(bsy));
        check({tag, ".a.seq_done"},    32'(ifa.seq_done),    32'(dn));
        check({tag, ".a.timeout_err"}, 32'(ifa.timeout_err), 32'(terr));
    endtask

    task automatic chk_b(input string tag, input logic [2:0] sr, input int cur,
                         input logic bsy, input logic dn);
        check({tag, ".b.stage_rst_n"}, 32'(ifb.stage_rst_n), 32'(sr));
        check({tag, ".b.cur_stage"},   32'(ifb.cur_stage),   cur);
        check({tag, ".b.busy"},        32'(ifb.busy),        32'(bsy));
        check({tag, ".b.seq_done"},    32'(ifb.seq_done),    32'(dn));
    endtask

    task automatic wait_edge(input int target);
        while (edge_n < target) @(negedge clk);
    endtask

    // One-cycle software request on sequencer a; returns on the negedge right
    // after the edge that sampled it.
    task automatic pulse_sw_a();
        ifa.sw_rst_req = 1'b1;
        @(negedge clk);
        ifa.sw_rst_req = 1'b0;
    endtask

    task automatic push_a(input int stage, input int edge_no);
        rel_t r;
        r.stage   = stage;
        r.edge_no = edge_no;
        qa.push_back(r);
    endtask

    task automatic push_b(input int stage, input int edge_no);
        rel_t r;
        r.stage   = stage;
        r.edge_no = edge_no;
        qb.push_back(r);
    endtask

    // Scoreboard for sequencer a: every rising stage reset must match the queue head.
    always @(negedge clk) begin
        for (int i = 0; i < NS; i++) begin
            if (ifa.stage_rst_n[i] === 1'b1 && prev_a[i] === 1'b0) begin
                rel_t e;
                e.stage   = NS;
                e.edge_no = -1;
                if (qa.size() > 0) e = qa.pop_front();
                check("a.release_stage", i, e.stage);
                check("a.release_edge", edge_n, e.edge_no);
            end
        end
        prev_a <= ifa.stage_rst_n;
    end

    // Scoreboard for sequencer b.
    always @(negedge clk) begin
        for (int i = 0; i < NS; i++) begin
            if (ifb.stage_rst_n[i] === 1'b1 && prev_b[i] === 1'b0) begin
                rel_t e;
                e.stage   = NS;
                e.edge_no = -1;
                if (qb.size() > 0) e = qb.pop_front();
                check("b.release_stage", i, e.stage);
                check("b.release_edge", edge_n, e.edge_no);
            end
        end
        prev_b <= ifb.stage_rst_n;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, checks passed %0d of %0d", n_pass, n_total);
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_pass          = 0;
        n_total         = 0;
        prev_a          = '0;
        prev_b          = '0;
        rst_n           = 1'b0;
        ifa.sw_rst_req  = 1'b0;
        ifa.stage_ready = 3'b111;
        ifb.sw_rst_req  = 1'b0;
        ifb.stage_ready = 3'b111;

        // Reset state
        repeat (3) @(negedge clk);
        chk_a("reset", 3'b000, 0, 1'b1, 1'b0, 3'b000);
        chk_b("reset", 3'b000, 0, 1'b1, 1'b0);

        // Power-up: rst_n rises before edge base+1
        rst_n = 1'b1;
        base  = edge_n;
        push_a(0, base + 17); push_a(1, base + 23); push_a(2, base + 29);
        push_b(0, base + 17); push_b(1, base + 19); push_b(2, base + 21);
        wait_edge(base + 16);
        chk_a("pu_hold_end", 3'b000, 0, 1'b1, 1'b0, 3'b000);
        wait_edge(base + 21);
        chk_b("pu_gap0_last", 3'b111, 2, 1'b1, 1'b0);
        wait_edge(base + 22);
        chk_b("pu_gap0_done", 3'b111, 2, 1'b0, 1'b1);
        wait_edge(base + 29);
        chk_a("pu_last_rel", 3'b111, 2, 1'b1, 1'b0, 3'b000);
        wait_edge(base + 30);
        chk_a("pu_done", 3'b111, 2, 1'b0, 1'b1, 3'b000);
        check("pu.qa_empty", qa.size(), 0);
        check("pu.qb_empty", qb.size(), 0);

        // Soft reset from DONE: same timing as power-up
        wait_edge(base + 33);
        pulse_sw_a();
        base = edge_n;
        chk_a("sw_from_done", 3'b000, 0, 1'b1, 1'b0, 3'b000);
        push_a(0, base + 17); push_a(1, base + 23); push_a(2, base + 29);
        wait_edge(base + 30);
        chk_a("sw_done", 3'b111, 2, 1'b0, 1'b1, 3'b000);
        check("sw.qa_empty", qa.size(), 0);

        // Ready handshake: stage 1 reports ready 50 cycles after its release
        ifa.stage_ready[1] = 1'b0;
        pulse_sw_a();
        base = edge_n;
        push_a(0, base + 17); push_a(1, base + 23); push_a(2, base + 79);
        wait_edge(base + 60);
        chk_a("hs_waiting", 3'b011, 1, 1'b1, 1'b0, 3'b000);
        wait_edge(base + 73);
        ifa.stage_ready[1] = 1'b1;
        wait_edge(base + 78);
        chk_a("hs_pre_rel", 3'b011, 2, 1'b1, 1'b0, 3'b000);
        wait_edge(base + 80);
        chk_a("hs_done", 3'b111, 2, 1'b0, 1'b1, 3'b000);
        check("hs.qa_empty", qa.size(), 0);

        // Soft reset in the gap after stage 1 released
        pulse_sw_a();
        base = edge_n;
        push_a(0, base + 17); push_a(1, base + 23);
        wait_edge(base + 25);
        pulse_sw_a();
        base2 = edge_n;
        chk_a("midgap_sw", 3'b000, 0, 1'b1, 1'b0, 3'b000);
        check("midgap.qa_empty", qa.size(), 0);
        push_a(0, base2 + 17); push_a(1, base2 + 23); push_a(2, base2 + 29);
        wait_edge(base2 + 16);
        chk_a("midgap_hold", 3'b000, 0, 1'b1, 1'b0, 3'b000);
        wait_edge(base2 + 30);
        chk_a("midgap_done", 3'b111, 2, 1'b0, 1'b1, 3'b000);
        check("midgap.qa_end", qa.size(), 0);

`ifdef RST_SEQ_TIMEOUT_EN
        // Stage 0 never reports ready: timeout after 8 wait cycles
        ifa.stage_ready[0] = 1'b0;
        pulse_sw_a();
        base = edge_n;
        push_a(0, base + 17); push_a(1, base + 30); push_a(2, base + 36);
        wait_edge(base + 24);
        chk_a("to_before", 3'b001, 0, 1'b1, 1'b0, 3'b000);
        wait_edge(base + 25);
        chk_a("to_flag", 3'b001, 0, 1'b1, 1'b0, 3'b001);
        wait_edge(base + 37);
        chk_a("to_done", 3'b111, 2, 1'b0, 1'b1, 3'b001);
        check("to.qa_empty", qa.size(), 0);
        ifa.stage_ready[0] = 1'b1;
        pulse_sw_a();
        chk_a("to_clear", 3'b000, 0, 1'b1, 1'b0, 3'b000);
`endif

        // Sequencer b is untouched by a's software requests
        chk_b("b_final", 3'b111, 2, 1'b0, 1'b1);
        check("final.qb_empty", qb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/rst_sequencer.md
Name: rst_sequencer

Overview:
- Staged reset controller for the SNN accelerator. Fans one synchronised reset out to NUM_STAGES sub-block resets (e.g. AXI interface, spike router, neuron array, weight memory).
- All stage resets assert together. They then release in index order 0..NUM_STAGES-1: fixed hold period, per-stage ready handshake, programmable gap between releases.
- Software can re-run the full sequence via a one-cycle request from the control register block.

Parameters:
NUM_STAGES, 4, number of sequenced reset outputs (>=2)
HOLD_CYCLES, 16, cycles all stage resets stay asserted before stage 0 releases (>=1)
GAP_CYCLES, 4, idle cycles after stage i reports ready, before stage i+1 releases (0 allowed)
TIMEOUT_CYCLES, 1024, max cycles to wait for stage_ready (used only with RST_SEQ_TIMEOUT_EN)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset, already synchronised upstream
sw_rst_req  input  1  one-cycle pulse; restarts the full sequence
stage_ready  input  NUM_STAGES  per-stage "init complete"; level, sampled only while waiting on that stage
stage_rst_n  output  NUM_STAGES  active-low reset per stage, registered
cur_stage  output  max(1,$clog2(NUM_STAGES))  index of stage currently being released/awaited
busy  output  1  high while sequence in progress
seq_done  output  1  high when all stages released and ready
timeout_err  output  NUM_STAGES  sticky per-stage timeout flags

Behaviour:
- rst_n low (asynchronous): stage_rst_n=0, cur_stage=0, busy=1, seq_done=0, timeout_err=0; state=HOLD, hold/gap/timeout counters=0.
- HOLD: hold_cnt increments each edge. At an edge where hold_cnt==HOLD_CYCLES-1, go to RELEASE.
- RELEASE (1 cycle): set stage_rst_n[cur_stage]=1; go to WAIT_READY. Released bits stay 1 until the next reset/sw request.
- WAIT_READY: on an edge with stage_ready[cur_stage]=1:
  - if cur_stage==NUM_STAGES-1, go to DONE;
  - else if GAP_CYCLES>0, go to GAP;
  - else cur_stage++ and go to RELEASE.
- GAP: gap_cnt increments each edge. At gap_cnt==GAP_CYCLES-1: clear gap_cnt, cur_stage++, go to RELEASE.
- DONE: busy=0, seq_done=1, both set at the transition edge. Terminal until sw_rst_req or rst_n.
- Release spacing: consecutive stage releases are 2+GAP_CYCLES cycles apart when ready is already high.
- stage_ready of non-current stages is ignored. Ready deasserting after its stage completed is ignored.
- sw_rst_req (highest priority, any state incl. HOLD):
  - next edge: stage_rst_n=0, cur_stage=0, busy=1, seq_done=0, timeout_err=0, all counters=0, state=HOLD;
  - a request during HOLD restarts the hold count.
- sw_rst_req held high for multiple cycles: sequence stays in HOLD with hold_cnt=0 until it drops.
- rst_n assertion mid-sequence: immediate return to reset values, no completion of the current step.
- Counters sized to their parameter; no wrap possible because each counter clears on its transition.

Optional Feature:
RST_SEQ_TIMEOUT_EN
- Defined:
  - WAIT_READY runs to_cnt from 0. If ready is not seen and to_cnt reaches TIMEOUT_CYCLES-1, set timeout_err[cur_stage]=1 and proceed exactly as if ready had arrived (GAP/RELEASE/DONE).
  - to_cnt clears on leaving WAIT_READY.
  - seq_done still asserts; timeout_err reports which stage failed.
- Undefined: WAIT_READY waits indefinitely; timeout_err tied to 0; no timeout counter logic synthesised.

Test Plan:
- Power-up, NUM_STAGES=3, HOLD=16, GAP=4, stage_ready=3'b111: rst_n rises before edge 1.
  - stage_rst_n[0] rises after edge 17, [1] after edge 23, [2] after edge 29.
  - seq_done=1 and busy=0 after edge 30.
- Ready handshake: stage_ready[1] held low until 50 cycles after stage_rst_n[1] rises.
  - cur_stage stays 1; stage_rst_n[2] stays 0.
  - stage 2 releases exactly 1+GAP+1=6 cycles after ready[1] is sampled high.
- Soft reset from DONE: pulse sw_rst_req one cycle.
  - next edge: stage_rst_n=000, seq_done=0, busy=1.
  - full sequence repeats with the same timing as the power-up test.
- Soft reset mid-GAP after stage 1 released: all outputs return to 0, sequence restarts at stage 0, no stage 2 release before the new hold completes.
- GAP_CYCLES=0, ready all high: releases spaced exactly 2 cycles apart.
- With RST_SEQ_TIMEOUT_EN, TIMEOUT=8, stage_ready[0]=0 permanently:
  - timeout_err=001 after 8 WAIT_READY cycles;
  - stage 1 releases after GAP; seq_done=1 at end;
  - a following sw_rst_req clears timeout_err to 000.
